// File: rtl/ipsxb_distributed_fifo_wr_adapter_v1_0.sv
// Write-side packet adapter feeding the distributed FIFO controller; admits a packet only when a full burst fits.
// Optional statistics counters are enabled by defining IPSXB_FIFO_WR_STATS_EN.
module ipsxb_distributed_fifo_wr_adapter_v1_0 #(
    parameter int DEPTH      = 9,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 16
) (
    input  logic                  wr_clk,
    input  logic                  wrst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    input  logic [DEPTH:0]        wr_water_level,
    input  logic                  wfull,
    output logic                  w_en,
    output logic [DATA_WIDTH:0]   w_data,
    output logic                  pkt_err,
    output logic [15:0]           pkt_cnt,
    output logic [15:0]           trunc_cnt
);

    localparam int CW = $clog2(BURST_LEN + 1);
    localparam logic [DEPTH+1:0] CAPACITY  = (DEPTH+2)'(2 ** DEPTH);
    localparam logic [DEPTH+1:0] BURST_THR = (DEPTH+2)'(BURST_LEN);
    localparam logic [CW-1:0]    CNT_MAX   = CW'(BURST_LEN);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BURST = 2'd1;
    localparam logic [1:0] ST_DROP  = 2'd2;

    generate
        if (BURST_LEN < 1 || BURST_LEN > (2 ** DEPTH)) begin : g_bad_burst_len
            $error("BURST_LEN must be within 1..2^DEPTH");
        end
    endgenerate

    logic [1:0]            r_state;
    logic [CW-1:0]         r_beat_cnt;
    logic                  r_w_en;
    logic [DATA_WIDTH:0]   r_w_data;
    logic                  r_pkt_err;

    logic [DEPTH+1:0]      w_free_eff;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_write;
    logic [CW-1:0]         w_cnt_next;
    logic                  w_trunc;

    // Free space already discounts the write currently on w_en, which the controller has not yet counted.
    assign w_free_eff = CAPACITY - {1'b0, wr_water_level} - {{(DEPTH+1){1'b0}}, r_w_en};

    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            ST_IDLE:  w_ready = (w_free_eff >= BURST_THR) && !wfull;
            ST_BURST: w_ready = 1'b1;
            ST_DROP:  w_ready = 1'b1;
            default:  w_ready = 1'b0;
        endcase
    end

    assign s_ready  = w_ready & ~wrst;
    assign w_accept = s_valid & s_ready;
    assign w_write  = w_accept && (r_state != ST_DROP);

    // The first beat of a packet always counts as 1, so BURST_LEN=1 truncates straight from IDLE.
    assign w_cnt_next = (r_state == ST_IDLE) ? CW'(1) : r_beat_cnt + CW'(1);
    assign w_trunc    = w_write && !s_last && (w_cnt_next == CNT_MAX);

    always_ff @(posedge wr_clk or posedge wrst) begin
        if (wrst) begin
            r_state    <= ST_IDLE;
            r_beat_cnt <= '0;
            r_w_en     <= 1'b0;
            r_w_data   <= '0;
            r_pkt_err  <= 1'b0;
        end else begin
            r_w_en    <= w_write;
            r_pkt_err <= w_trunc;
            if (w_write) begin
                r_w_data <= {s_last | w_trunc, s_data};
            end
            if (w_accept) begin
                if (s_last) begin
                    r_state    <= ST_IDLE;
                    r_beat_cnt <= '0;
                end else if (r_state == ST_DROP) begin
                    r_state <= ST_DROP;
                end else if (w_trunc) begin
                    r_state    <= ST_DROP;
                    r_beat_cnt <= w_cnt_next;
                end else begin
                    r_state    <= ST_BURST;
                    r_beat_cnt <= w_cnt_next;
                end
            end
        end
    end

    assign w_en    = r_w_en;
    assign w_data  = r_w_data;
    assign pkt_err = r_pkt_err;

`ifdef IPSXB_FIFO_WR_STATS_EN
    logic [15:0] r_pkt_cnt;
    logic [15:0] r_trunc_cnt;

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge wr_clk or posedge wrst) begin
        if (wrst) begin
            r_pkt_cnt   <= '0;
            r_trunc_cnt <= '0;
        end else begin
            if (r_w_en && r_w_data[DATA_WIDTH] && (r_pkt_cnt != 16'hFFFF)) begin
                r_pkt_cnt <= r_pkt_cnt + 16'd1;
            end
            if (r_pkt_err && (r_trunc_cnt != 16'hFFFF)) begin
                r_trunc_cnt <= r_trunc_cnt + 16'd1;
            end
        end
    end

    assign pkt_cnt   = r_pkt_cnt;
    assign trunc_cnt = r_trunc_cnt;
`else
    assign pkt_cnt   = 16'd0;
    assign trunc_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_ipsxb_distributed_fifo_wr_adapter_v1_0.sv
// Scoreboard bench for the FIFO write adapter (DEPTH=4, DATA_WIDTH=8, BURST_LEN=4).
module tb_ipsxb_distributed_fifo_wr_adapter_v1_0;

    localparam int DEPTH = 4;
    localparam int DW    = 8;
    localparam int BL    = 4;
`ifdef IPSXB_FIFO_WR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          wr_clk = 1'b0;
    logic          wrst;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic [DEPTH:0] wr_water_level;
    logic          wfull;
    logic          w_en;
    logic [DW:0]   w_data;
    logic          pkt_err;
    logic [15:0]   pkt_cnt;
    logic [15:0]   trunc_cnt;

    logic [DW+1:0] expQ[$];
    int  total = 0;
    int  bad = 0;
    int  beatIdx = 0;
    bit  monitorOn = 1'b0;

    ipsxb_distributed_fifo_wr_adapter_v1_0 #(
        .DEPTH(DEPTH), .DATA_WIDTH(DW), .BURST_LEN(BL)
    ) dut (
        .wr_clk(wr_clk), .wrst(wrst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .wr_water_level(wr_water_level), .wfull(wfull),
        .w_en(w_en), .w_data(w_data), .pkt_err(pkt_err),
        .pkt_cnt(pkt_cnt), .trunc_cnt(trunc_cnt)
    );

    always #5 wr_clk = ~wr_clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Reference packet model: beats past BURST_LEN vanish, the BURST_LEN-th beat is forced last.
    task automatic modelAccept(input logic [DW-1:0] d, input logic last);
        beatIdx++;
        if (beatIdx < BL) begin
            expQ.push_back({1'b0, last, d});
        end else if (beatIdx == BL) begin
            expQ.push_back({~last, 1'b1, d});
        end
        if (last) beatIdx = 0;
    endtask

    task automatic applyStimulus(input logic [DW-1:0] d, input logic last);
        int waited;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        waited  = 0;
        @(negedge wr_clk);
        while (!s_ready && waited < 50) begin
            @(negedge wr_clk);
            waited++;
        end
        if (!s_ready) begin
            checkOutput("acceptTimeout", 32'd0, 32'd1);
        end else begin
            modelAccept(d, last);
        end
        @(posedge wr_clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge wr_clk);
        #1;
    endtask

    always @(negedge wr_clk) begin
        if (monitorOn && !wrst) begin
            if (w_en) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedWrite", {23'd0, pkt_err, w_data}, 32'hFFFFFFFF);
                end else begin
                    checkOutput("writeWord", {22'd0, pkt_err, w_data}, {22'd0, expQ.pop_front()});
                end
            end else if (pkt_err) begin
                checkOutput("errWithoutWrite", 32'd1, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        wrst = 1'b1;
        s_valid = 1'b0;
        s_data = '0;
        s_last = 1'b0;
        wr_water_level = '0;
        wfull = 1'b0;
        idleCycles(3);
        checkOutput("readyInReset", {31'd0, s_ready}, 32'd0);
        wrst = 1'b0;
        @(negedge wr_clk);
        checkOutput("readyAfterReset", {31'd0, s_ready}, 32'd1);
        checkOutput("wenAfterReset", {31'd0, w_en}, 32'd0);
        checkOutput("wdataAfterReset", {23'd0, w_data}, 32'h000);
        checkOutput("errAfterReset", {31'd0, pkt_err}, 32'd0);
        checkOutput("pktCntReset", {16'd0, pkt_cnt}, 32'd0);
        checkOutput("truncCntReset", {16'd0, trunc_cnt}, 32'd0);
        monitorOn = 1'b1;
        @(posedge wr_clk);
        #1;

        applyStimulus(8'hAA, 1'b0);
        applyStimulus(8'hBB, 1'b0);
        applyStimulus(8'hCC, 1'b1);
        idleCycles(3);
        checkOutput("drainShortPkt", expQ.size(), 32'd0);
        checkOutput("pktCntShort", {16'd0, pkt_cnt}, STATS ? 32'd1 : 32'd0);

        wr_water_level = 5'd13;
        @(negedge wr_clk);
        checkOutput("gateLevel13", {31'd0, s_ready}, 32'd0);
        @(posedge wr_clk);
        #1;
        wr_water_level = 5'd12;
        @(negedge wr_clk);
        checkOutput("gateLevel12", {31'd0, s_ready}, 32'd1);
        @(posedge wr_clk);
        #1;
        wr_water_level = 5'd0;
        wfull = 1'b1;
        @(negedge wr_clk);
        checkOutput("gateWfull", {31'd0, s_ready}, 32'd0);
        @(posedge wr_clk);
        #1;
        wfull = 1'b0;

        for (int i = 1; i <= 6; i++) begin
            applyStimulus(8'(i), (i == 6) ? 1'b1 : 1'b0);
        end
        idleCycles(3);
        checkOutput("drainTrunc", expQ.size(), 32'd0);
        checkOutput("truncCnt", {16'd0, trunc_cnt}, STATS ? 32'd1 : 32'd0);
        checkOutput("pktCntTrunc", {16'd0, pkt_cnt}, STATS ? 32'd2 : 32'd0);

        wr_water_level = 5'd12;
        applyStimulus(8'h55, 1'b1);
        @(negedge wr_clk);
        checkOutput("inflightWen", {31'd0, w_en}, 32'd1);
        checkOutput("inflightReady", {31'd0, s_ready}, 32'd0);
        @(negedge wr_clk);
        checkOutput("inflightReadyBack", {31'd0, s_ready}, 32'd1);
        @(posedge wr_clk);
        #1;
        wr_water_level = 5'd0;
        idleCycles(2);
        checkOutput("pktCntInflight", {16'd0, pkt_cnt}, STATS ? 32'd3 : 32'd0);

        applyStimulus(8'h11, 1'b0);
        applyStimulus(8'h22, 1'b0);
        @(negedge wr_clk);
        #1;
        wrst = 1'b1;
        beatIdx = 0;
        #1;
        checkOutput("midResetWen", {31'd0, w_en}, 32'd0);
        checkOutput("midResetReady", {31'd0, s_ready}, 32'd0);
        checkOutput("midResetQueue", expQ.size(), 32'd0);
        @(posedge wr_clk);
        #1;
        wrst = 1'b0;
        checkOutput("midResetPktCnt", {16'd0, pkt_cnt}, 32'd0);
        applyStimulus(8'h71, 1'b0);
        applyStimulus(8'h72, 1'b0);
        applyStimulus(8'h73, 1'b0);
        applyStimulus(8'h74, 1'b1);
        idleCycles(3);
        checkOutput("drainAfterReset", expQ.size(), 32'd0);
        checkOutput("pktCntAfterReset", {16'd0, pkt_cnt}, STATS ? 32'd1 : 32'd0);
        checkOutput("truncCntAfterReset", {16'd0, trunc_cnt}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
